neuraedge_npu_50_tops: RTL and testbench

- Top-level NPU shell with a 32-bit CSR slave, a 64-lane byte-wide reduction datapath, thermal/power throttling, and a DRAM-contention stall injector.
- The contention injector is programmed through CSR 0xD4.
- Streaming data beats are reduced into an accumulator under precision and sparsity modes.
- Results and status are read back over the CSR bus; used as the single-tile prototype in system benches.

---
 rtl/neuraedge_npu_50_tops_if.sv | 21 ++
 rtl/neuraedge_npu_50_tops.sv | 246 ++++++++++++++++++++++++
 tb/tb_neuraedge_npu_50_tops.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/neuraedge_npu_50_tops_if.sv
// CSR slave bus for the NeuraEdge NPU tile.
//   csr_valid/csr_write/csr_addr/csr_wdata : request, driven by the master
//   csr_rdata/csr_ready                    : one-cycle completion, driven by the slave
interface neuraedge_npu_50_tops_if;
    logic        csr_valid;
    logic        csr_write;
    logic [7:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_ready;

    modport master (
        output csr_valid, csr_write, csr_addr, csr_wdata,
        input  csr_rdata, csr_ready
    );

    modport slave (
        input  csr_valid, csr_write, csr_addr, csr_wdata,
        output csr_rdata, csr_ready
    );
endinterface

// File: rtl/neuraedge_npu_50_tops.sv
// NeuraEdge 50-TOPS NPU single-tile shell.
// Reduces 64-lane byte beats into a 32-bit accumulator under int8/int4x2/uint8
// precision, throttles on temperature or power-off, injects periodic DRAM
// contention stalls, and exposes control/status over a 32-bit CSR slave.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   power_mode                : 8'hFF blocks all data acceptance
//   system_power_budget_mw    : budget feeding the EFF_TOPS report
//   chip_temperature          : die temperature compared against THERMAL
//   performance_target_tops   : requested throughput for EFF_TOPS
//   global_sparsity_enable/mode, global_precision_mode : datapath modes
//   data_in, data_valid       : streaming beats, no backpressure
//   csr                       : CSR slave interface
// Optional feature: define NPU_PERF_COUNTERS_EN to build BEATS/ZSKIP/STALLS;
// otherwise those read 0 and clear_counters affects only ACC.
module neuraedge_npu_50_tops #(
    parameter int unsigned LANES             = 64,
    parameter int unsigned THERMAL_LIMIT_RST = 85,
    parameter int unsigned MAX_TOPS          = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           power_mode,
    input  logic [15:0]          system_power_budget_mw,
    input  logic [7:0]           chip_temperature,
    input  logic [15:0]          performance_target_tops,
    input  logic                 global_sparsity_enable,
    input  logic [1:0]           global_sparsity_mode,
    input  logic [1:0]           global_precision_mode,
    input  logic [8*LANES-1:0]   data_in,
    input  logic                 data_valid,
    neuraedge_npu_50_tops_if.slave csr
);

    localparam logic [7:0]  ADDR_ID      = 8'h00;
    localparam logic [7:0]  ADDR_CTRL    = 8'h04;
    localparam logic [7:0]  ADDR_STATUS  = 8'h08;
    localparam logic [7:0]  ADDR_ACC     = 8'h0C;
    localparam logic [7:0]  ADDR_BEATS   = 8'h10;
    localparam logic [7:0]  ADDR_ZSKIP   = 8'h14;
    localparam logic [7:0]  ADDR_STALLS  = 8'h18;
    localparam logic [7:0]  ADDR_THERMAL = 8'h1C;
    localparam logic [7:0]  ADDR_EFF     = 8'h20;
    localparam logic [7:0]  ADDR_CONT    = 8'hD4;
    localparam logic [31:0] ID_VALUE     = 32'h4E45_5030;
    localparam logic [19:0] CONT_RST     = 20'h0_4100;
    localparam logic [19:0] CONT_MASK    = 20'hF_FFF1;
    localparam logic [15:0] MAX_TOPS_W   = 16'(MAX_TOPS);
    localparam logic [7:0]  THERMAL_RST_W = 8'(THERMAL_LIMIT_RST);

    // Registered state
    logic        ready_q,   ready_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic [7:0]  thermal_q, thermal_d;
    logic [19:0] cont_q,    cont_d;
    logic [7:0]  phase_q,   phase_d;
    logic [31:0] acc_q,     acc_d;

    // Combinational helpers
    logic        csr_acc_c, wr_c, clear_c;
    logic        throttled_c, stall_c, accept_c;
    logic [1:0]  prec_c;
    logic [7:0]  period_c;
    logic [31:0] beat_sum_c;
    logic [15:0] eff_t1_c, eff_t2_c, eff_c;
    logic [31:0] rd_mux_c;

`ifdef NPU_PERF_COUNTERS_EN
    localparam int unsigned ZW = $clog2(2*LANES + 1);
    logic [31:0]   beats_q,  beats_d;
    logic [31:0]   zskip_q,  zskip_d;
    logic [31:0]   stalls_q, stalls_d;
    logic [ZW-1:0] zero_cnt_c;
    logic          nibble_zero_c;
`endif

    // Bits of the bus that no register stores
    logic unused_c;
`ifdef NPU_PERF_COUNTERS_EN
    assign unused_c = ^{csr.csr_wdata[31:20]};
`else
    assign unused_c = ^{csr.csr_wdata[31:20], global_sparsity_enable, global_sparsity_mode};
`endif

    // CSR acceptance: only while no completion is pending
    always_comb begin
        csr_acc_c = csr.csr_valid && !ready_q;
        wr_c      = csr_acc_c && csr.csr_write;
        clear_c   = wr_c && (csr.csr_addr == ADDR_CTRL) && csr.csr_wdata[1];
    end

    // Throttle, contention stall and beat acceptance
    always_comb begin
        prec_c      = (global_precision_mode == 2'd3) ? 2'd0 : global_precision_mode;
        throttled_c = (chip_temperature >= thermal_q) || (power_mode == 8'hFF);
        period_c    = (cont_q[11:4] == 8'd0) ? 8'd1 : cont_q[11:4];
        stall_c     = cont_q[0] && (phase_q < cont_q[19:12]);
        accept_c    = data_valid && ctrl_en_q && !throttled_c && !stall_c;
    end

    // Lane reduction under the effective precision
    always_comb begin
        beat_sum_c = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            case (prec_c)
                2'd1: beat_sum_c = beat_sum_c
                                 + {{28{data_in[8*k+3]}}, data_in[8*k +: 4]}
                                 + {{28{data_in[8*k+7]}}, data_in[8*k+4 +: 4]};
                2'd2: beat_sum_c = beat_sum_c + {24'd0, data_in[8*k +: 8]};
                default: beat_sum_c = beat_sum_c + {{24{data_in[8*k+7]}}, data_in[8*k +: 8]};
            endcase
        end
    end

`ifdef NPU_PERF_COUNTERS_EN
    // Zero-element count: nibbles only in int4 precision with sparsity mode 1
    always_comb begin
        nibble_zero_c = (prec_c == 2'd1) && (global_sparsity_mode == 2'd1);
        zero_cnt_c    = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (nibble_zero_c) begin
                if (data_in[8*k +: 4] == 4'd0)   zero_cnt_c = zero_cnt_c + ZW'(1);
                if (data_in[8*k+4 +: 4] == 4'd0) zero_cnt_c = zero_cnt_c + ZW'(1);
            end else if (data_in[8*k +: 8] == 8'd0) begin
                zero_cnt_c = zero_cnt_c + ZW'(1);
            end
        end
    end
`endif

    // Effective TOPS: cap, budget clamp, then halve when throttled
    always_comb begin
        eff_t1_c = (performance_target_tops > MAX_TOPS_W) ? MAX_TOPS_W : performance_target_tops;
        eff_t2_c = ((system_power_budget_mw < 16'd500) && (eff_t1_c > 16'd25)) ? 16'd25 : eff_t1_c;
        eff_c    = throttled_c ? (eff_t2_c >> 1) : eff_t2_c;
    end

    // CSR read mux
    always_comb begin
        rd_mux_c = '0;
        case (csr.csr_addr)
            ADDR_ID:      rd_mux_c = ID_VALUE;
            ADDR_CTRL:    rd_mux_c = {31'd0, ctrl_en_q};
            ADDR_STATUS:  rd_mux_c = {26'd0, prec_c, 1'b0, stall_c, throttled_c, ctrl_en_q};
            ADDR_ACC:     rd_mux_c = acc_q;
`ifdef NPU_PERF_COUNTERS_EN
            ADDR_BEATS:   rd_mux_c = beats_q;
            ADDR_ZSKIP:   rd_mux_c = zskip_q;
            ADDR_STALLS:  rd_mux_c = stalls_q;
`endif
            ADDR_THERMAL: rd_mux_c = {24'd0, thermal_q};
            ADDR_EFF:     rd_mux_c = {16'd0, eff_c};
            ADDR_CONT:    rd_mux_c = {12'd0, cont_q};
            default:      rd_mux_c = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        ready_d   = csr_acc_c;
        rdata_d   = rdata_q;
        ctrl_en_d = ctrl_en_q;
        thermal_d = thermal_q;
        cont_d    = cont_q;
        acc_d     = acc_q;
        phase_d   = (phase_q >= period_c - 8'd1) ? 8'd0 : phase_q + 8'd1;
`ifdef NPU_PERF_COUNTERS_EN
        beats_d   = beats_q;
        zskip_d   = zskip_q;
        stalls_d  = stalls_q;
`endif

        if (csr_acc_c) begin
            rdata_d = csr.csr_write ? 32'd0 : rd_mux_c;
        end

        if (wr_c) begin
            case (csr.csr_addr)
                ADDR_CTRL:    ctrl_en_d = csr.csr_wdata[0];
                ADDR_THERMAL: thermal_d = csr.csr_wdata[7:0];
                ADDR_CONT: begin
                    cont_d  = csr.csr_wdata[19:0] & CONT_MASK;
                    phase_d = 8'd0;
                end
                default: ;
            endcase
        end

        // Clear wins over a same-cycle increment
        if (clear_c) begin
            acc_d = '0;
        end else if (accept_c) begin
            acc_d = acc_q + beat_sum_c;
        end

`ifdef NPU_PERF_COUNTERS_EN
        if (clear_c) begin
            beats_d  = '0;
            zskip_d  = '0;
            stalls_d = '0;
        end else begin
            if (accept_c) begin
                beats_d = beats_q + 32'd1;
                if (global_sparsity_enable) zskip_d = zskip_q + 32'(zero_cnt_c);
            end
            if (data_valid && ctrl_en_q && !accept_c) stalls_d = stalls_q + 32'd1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            ctrl_en_q <= 1'b0;
            thermal_q <= THERMAL_RST_W;
            cont_q    <= CONT_RST;
            phase_q   <= '0;
            acc_q     <= '0;
`ifdef NPU_PERF_COUNTERS_EN
            beats_q   <= '0;
            zskip_q   <= '0;
            stalls_q  <= '0;
`endif
        end else begin
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            ctrl_en_q <= ctrl_en_d;
            thermal_q <= thermal_d;
            cont_q    <= cont_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
`ifdef NPU_PERF_COUNTERS_EN
            beats_q   <= beats_d;
            zskip_q   <= zskip_d;
            stalls_q  <= stalls_d;
`endif
        end
    end

    assign csr.csr_ready = ready_q;
    assign csr.csr_rdata = rdata_q;

endmodule

// File: tb/tb_neuraedge_npu_50_tops.sv
// Directed self-checking bench for neuraedge_npu_50_tops.
module tb_neuraedge_npu_50_tops;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   power_mode;
    logic [15:0]  system_power_budget_mw;
    logic [7:0]   chip_temperature;
    logic [15:0]  performance_target_tops;
    logic         global_sparsity_enable;
    logic [1:0]   global_sparsity_mode;
    logic [1:0]   global_precision_mode;
    logic [511:0] data_in;
    logic         data_valid;

    int checks = 0;
    int errors = 0;

    neuraedge_npu_50_tops_if csr_if ();

    neuraedge_npu_50_tops dut (
        .clk                     (clk),
        .reset                   (reset),
        .power_mode              (power_mode),
        .system_power_budget_mw  (system_power_budget_mw),
        .chip_temperature        (chip_temperature),
        .performance_target_tops (performance_target_tops),
        .global_sparsity_enable  (global_sparsity_enable),
        .global_sparsity_mode    (global_sparsity_mode),
        .global_precision_mode   (global_precision_mode),
        .data_in                 (data_in),
        .data_valid              (data_valid),
        .csr                     (csr_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One CSR transaction; starts and ends 1 time unit after a rising edge
    task automatic csr_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd);
        csr_if.csr_valid = 1'b1;
        csr_if.csr_write = wr;
        csr_if.csr_addr  = addr;
        csr_if.csr_wdata = wd;
        @(posedge clk); #1;
        check("csr_ready_set", 32'(csr_if.csr_ready), 32'd1);
        rd = csr_if.csr_rdata;
        csr_if.csr_valid = 1'b0;
        @(posedge clk); #1;
        check("csr_ready_clr", 32'(csr_if.csr_ready), 32'd0);
    endtask

    task automatic csr_rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        csr_xfer(1'b0, addr, 32'd0, rd);
        check(tag, rd, exp);
    endtask

    task automatic csr_wr(input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        csr_xfer(1'b1, addr, wd, rd);
    endtask

    task automatic drive_beats(input logic [511:0] d, input int n);
        data_in    = d;
        data_valid = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    logic [511:0] ones, all_ff, pat;

    initial begin
        ones   = {64{8'h01}};
        all_ff = {64{8'hFF}};
        reset                   = 1'b1;
        power_mode              = 8'h00;
        system_power_budget_mw  = 16'd1000;
        chip_temperature        = 8'd25;
        performance_target_tops = 16'd100;
        global_sparsity_enable  = 1'b0;
        global_sparsity_mode    = 2'd0;
        global_precision_mode   = 2'd0;
        data_in                 = '0;
        data_valid              = 1'b0;
        csr_if.csr_valid        = 1'b0;
        csr_if.csr_write        = 1'b0;
        csr_if.csr_addr         = 8'h00;
        csr_if.csr_wdata        = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(csr_if.csr_ready), 32'd0);
        check("rst_rdata", csr_if.csr_rdata, 32'd0);
        reset = 1'b0;

        // Reset values
        csr_rd("id",          8'h00, 32'h4E45_5030);
        csr_rd("cont_rst",    8'hD4, 32'h0000_4100);
        csr_rd("thermal_rst", 8'h1C, 32'd85);
        csr_rd("ctrl_rst",    8'h04, 32'd0);
        csr_rd("acc_rst",     8'h0C, 32'd0);

        // Enable, three int8 beats of +1
        csr_wr(8'h04, 32'd1);
        drive_beats(ones, 3);
        csr_rd("acc_3beats", 8'h0C, 32'd192);

        // All 0xFF: signed int8 then unsigned int8
        drive_beats(all_ff, 1);
        csr_rd("acc_int8_ff", 8'h0C, 32'd128);
        global_precision_mode = 2'd2;
        drive_beats(all_ff, 1);
        csr_rd("acc_uint8_ff", 8'h0C, 32'd16448);
        global_precision_mode = 2'd0;

        // Sparsity: 10 zero byte lanes, remaining 54 lanes are +1
        global_sparsity_enable = 1'b1;
        pat = ones;
        for (int i = 0; i < 10; i++) pat[8*i +: 8] = 8'h00;
        drive_beats(pat, 1);
        csr_rd("acc_sparse", 8'h0C, 32'd16502);

        // int4x2 with nibble sparsity: lanes 0x0F = (-1) + 0, 64 zero nibbles
        global_precision_mode = 2'd1;
        global_sparsity_mode  = 2'd1;
        csr_rd("status_int4", 8'h08, 32'h0000_0011);
        drive_beats({64{8'h0F}}, 1);
        csr_rd("acc_int4", 8'h0C, 32'd16438);
`ifdef NPU_PERF_COUNTERS_EN
        csr_rd("zskip", 8'h14, 32'd74);
`else
        csr_rd("zskip_absent", 8'h14, 32'd0);
`endif
        global_precision_mode  = 2'd0;
        global_sparsity_mode   = 2'd0;
        global_sparsity_enable = 1'b0;

        // Contention P=16 S=4: valid held 32 edges right after the write
        data_in          = ones;
        csr_if.csr_valid = 1'b1;
        csr_if.csr_write = 1'b1;
        csr_if.csr_addr  = 8'hD4;
        csr_if.csr_wdata = 32'h0000_4101;
        @(posedge clk); #1;
        data_valid       = 1'b1;
        check("cont_wr_ready", 32'(csr_if.csr_ready), 32'd1);
        csr_if.csr_valid = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        data_valid = 1'b0;
        // Phase at the next three accepts is 0, 2, 4
        csr_rd("status_stall_p0", 8'h08, 32'h0000_0005);
        csr_rd("status_stall_p2", 8'h08, 32'h0000_0005);
        csr_rd("status_stall_p4", 8'h08, 32'h0000_0001);
        csr_rd("acc_contention", 8'h0C, 32'd17974);
`ifdef NPU_PERF_COUNTERS_EN
        csr_rd("stalls_cont", 8'h18, 32'd8);
`else
        csr_rd("stalls_absent", 8'h18, 32'd0);
`endif

        // Contention off: every beat accepted
        csr_wr(8'hD4, 32'd0);
        drive_beats(ones, 10);
        csr_rd("acc_nocont", 8'h0C, 32'd18614);
`ifdef NPU_PERF_COUNTERS_EN
        csr_rd("beats_total",   8'h10, 32'd41);
        csr_rd("stalls_nocont", 8'h18, 32'd8);
`else
        csr_rd("beats_absent", 8'h10, 32'd0);
`endif

        // Thermal throttle
        chip_temperature = 8'd90;
        csr_rd("status_hot", 8'h08, 32'h0000_0003);
        drive_beats(ones, 5);
        csr_rd("acc_hot", 8'h0C, 32'd18614);
`ifdef NPU_PERF_COUNTERS_EN
        csr_rd("stalls_hot", 8'h18, 32'd13);
`endif
        csr_rd("eff_hot", 8'h20, 32'd25);
        chip_temperature = 8'd85;
        csr_rd("status_at_limit", 8'h08, 32'h0000_0003);
        chip_temperature = 8'd50;
        csr_rd("status_cool", 8'h08, 32'h0000_0001);
        csr_rd("eff_cool", 8'h20, 32'd50);
        system_power_budget_mw = 16'd400;
        csr_rd("eff_budget", 8'h20, 32'd25);
        power_mode = 8'hFF;
        csr_rd("status_poweroff", 8'h08, 32'h0000_0003);
        csr_rd("eff_poweroff", 8'h20, 32'd12);
        drive_beats(ones, 2);
        csr_rd("acc_poweroff", 8'h0C, 32'd18614);
        power_mode             = 8'h00;
        system_power_budget_mw = 16'd1000;

        // Clear counters; enable also goes low
        csr_wr(8'h04, 32'd2);
        csr_rd("ctrl_after_clr", 8'h04, 32'd0);
        csr_rd("acc_clr",        8'h0C, 32'd0);
        csr_rd("beats_clr",      8'h10, 32'd0);
        csr_rd("zskip_clr",      8'h14, 32'd0);
        csr_rd("stalls_clr",     8'h18, 32'd0);
        csr_rd("status_clr",     8'h08, 32'd0);

        // Register widths and unmapped space
        csr_wr(8'h1C, 32'h0000_0123);
        csr_rd("thermal_rw", 8'h1C, 32'h0000_0023);
        csr_wr(8'h40, 32'hDEAD_BEEF);
        csr_rd("unmapped", 8'h40, 32'd0);

        // Reset during a pending request aborts it and restores defaults
        csr_if.csr_valid = 1'b1;
        csr_if.csr_write = 1'b0;
        csr_if.csr_addr  = 8'h00;
        reset            = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ready", 32'(csr_if.csr_ready), 32'd0);
        check("rst_mid_rdata", csr_if.csr_rdata, 32'd0);
        csr_if.csr_valid = 1'b0;
        reset            = 1'b0;
        csr_rd("thermal_rerst", 8'h1C, 32'd85);
        csr_rd("cont_rerst",    8'hD4, 32'h0000_4100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
